// File: rtl/powlib_ipsaxi_wrarb.sv
// N-to-1 AXI write-channel arbiter: round-robin on AW, W locked to the granted
// master until wlast, B routed back by the master index carried in the upper ID bits.
module powlib_ipsaxi_wrarb #(
  parameter int NM    = 2,
  parameter int SELW  = 2,
  parameter int IDW   = 1,
  parameter int B_BPD = 4,
  parameter int B_AW  = 8*B_BPD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NM*IDW-1:0]      s_awid,
  input  logic [NM*B_AW-1:0]     s_awaddr,
  input  logic [NM*8-1:0]        s_awlen,
  input  logic [NM*3-1:0]        s_awsize,
  input  logic [NM*2-1:0]        s_awburst,
  input  logic [NM-1:0]          s_awvalid,
  output logic [NM-1:0]          s_awready,
  input  logic [NM*8*B_BPD-1:0]  s_wdata,
  input  logic [NM*B_BPD-1:0]    s_wstrb,
  input  logic [NM-1:0]          s_wlast,
  input  logic [NM-1:0]          s_wvalid,
  output logic [NM-1:0]          s_wready,
  output logic [IDW-1:0]         s_bid,
  output logic [1:0]             s_bresp,
  output logic [NM-1:0]          s_bvalid,
  input  logic [NM-1:0]          s_bready,
  output logic [SELW+IDW-1:0]    m_awid,
  output logic [B_AW-1:0]        m_awaddr,
  output logic [7:0]             m_awlen,
  output logic [2:0]             m_awsize,
  output logic [1:0]             m_awburst,
  output logic                   m_awvalid,
  input  logic                   m_awready,
  output logic [8*B_BPD-1:0]     m_wdata,
  output logic [B_BPD-1:0]       m_wstrb,
  output logic                   m_wlast,
  output logic                   m_wvalid,
  input  logic                   m_wready,
  input  logic [SELW+IDW-1:0]    m_bid,
  input  logic [1:0]             m_bresp,
  input  logic                   m_bvalid,
  output logic                   m_bready,
  output logic                   err
);
  localparam int B_DW  = 8*B_BPD;
  localparam int B_BEW = B_BPD;
  localparam int NS    = 1 << SELW;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_t;

  state_t              r_state, w_state_nxt;
  logic [SELW-1:0]     r_rr, r_grant;
  logic [SELW+IDW-1:0] r_awid;
  logic [B_AW-1:0]     r_awaddr;
  logic [7:0]          r_awlen;
  logic [2:0]          r_awsize;
  logic [1:0]          r_awburst;

  // Per-master bit vectors widened to the full index space so SELW-bit
  // indices select them without width mismatch.
  logic [NS-1:0]       w_awv_ext, w_wv_ext, w_wlast_ext, w_bready_ext;
  logic [NS-1:0]       w_awr_ext, w_wr_ext, w_bv_ext;
  logic [SELW:0]       w_sum;
  logic [SELW-1:0]     w_idx, w_winner, w_bsel;
  logic                w_found, w_bok, w_wlast_hs;

  assign w_awv_ext    = NS'(s_awvalid);
  assign w_wv_ext     = NS'(s_wvalid);
  assign w_wlast_ext  = NS'(s_wlast);
  assign w_bready_ext = NS'(s_bready);

  always_comb begin : arb
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NM; i++) begin
      w_sum = {1'b0, r_rr} + (SELW+1)'(i);
      if (w_sum >= (SELW+1)'(NM)) w_sum = w_sum - (SELW+1)'(NM);
      w_idx = w_sum[SELW-1:0];
      if (!w_found && w_awv_ext[w_idx]) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end

  always_comb begin : fsm
    w_state_nxt = r_state;
    w_awr_ext   = '0;
    w_wr_ext    = '0;
    m_awvalid   = 1'b0;
    m_wvalid    = 1'b0;
    m_wdata     = s_wdata[r_grant*B_DW +: B_DW];
    m_wstrb     = s_wstrb[r_grant*B_BEW +: B_BEW];
    m_wlast     = w_wlast_ext[r_grant];
    w_wlast_hs  = 1'b0;
    if (!rst) begin
      unique case (r_state)
        ST_IDLE: if (w_found) begin
          w_awr_ext[w_winner] = 1'b1;
          w_state_nxt         = ST_ADDR;
        end
        ST_ADDR: begin
          m_awvalid = 1'b1;
          if (m_awready) w_state_nxt = ST_DATA;
        end
        ST_DATA: begin
          m_wvalid          = w_wv_ext[r_grant];
          w_wr_ext[r_grant] = m_wready;
          w_wlast_hs        = m_wvalid && m_wready && m_wlast;
          if (w_wlast_hs) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign s_awready = w_awr_ext[NM-1:0];
  assign s_wready  = w_wr_ext[NM-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_rr      <= '0;
      r_grant   <= '0;
      r_awid    <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awsize  <= '0;
      r_awburst <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_found) begin
        r_grant   <= w_winner;
        r_awid    <= {w_winner, s_awid[w_winner*IDW +: IDW]};
        r_awaddr  <= s_awaddr[w_winner*B_AW +: B_AW];
        r_awlen   <= s_awlen[w_winner*8 +: 8];
        r_awsize  <= s_awsize[w_winner*3 +: 3];
        r_awburst <= s_awburst[w_winner*2 +: 2];
      end
      if (w_wlast_hs)
        r_rr <= (r_grant == SELW'(NM-1)) ? '0 : r_grant + SELW'(1);
    end
  end

  assign m_awid    = r_awid;
  assign m_awaddr  = r_awaddr;
  assign m_awlen   = r_awlen;
  assign m_awsize  = r_awsize;
  assign m_awburst = r_awburst;

  // Responses carrying an index with no master behind it are swallowed.
  assign w_bsel = m_bid[IDW +: SELW];
  assign w_bok  = ({1'b0, w_bsel} < (SELW+1)'(NM));

  always_comb begin : bpath
    w_bv_ext = '0;
    m_bready = 1'b0;
    err      = 1'b0;
    if (!rst) begin
      if (w_bok) begin
        w_bv_ext[w_bsel] = m_bvalid;
        m_bready         = w_bready_ext[w_bsel];
      end else begin
        m_bready = 1'b1;
        err      = m_bvalid;
      end
    end
  end

  assign s_bvalid = w_bv_ext[NM-1:0];
  assign s_bid    = m_bid[IDW-1:0];
  assign s_bresp  = m_bresp;
endmodule

// File: tb/tb_powlib_ipsaxi_wrarb.sv
// Randomized bench for powlib_ipsaxi_wrarb: a transaction-level arbiter model
// predicts every output each cycle, with directed scenarios pinning the model.
module tb_powlib_ipsaxi_wrarb;
  localparam int NM = 3, SELW = 2, IDW = 2, B_BPD = 4, B_AW = 32;
  localparam int B_DW = 32, B_BEW = 4, BIDW = SELW + IDW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NM*IDW-1:0]   s_awid = '0;
  logic [NM*B_AW-1:0]  s_awaddr = '0;
  logic [NM*8-1:0]     s_awlen = '0;
  logic [NM*3-1:0]     s_awsize = '0;
  logic [NM*2-1:0]     s_awburst = '0;
  logic [NM-1:0]       s_awvalid = '0, s_awready;
  logic [NM*B_DW-1:0]  s_wdata = '0;
  logic [NM*B_BEW-1:0] s_wstrb = '0;
  logic [NM-1:0]       s_wlast = '0, s_wvalid = '0, s_wready;
  logic [IDW-1:0]      s_bid;
  logic [1:0]          s_bresp;
  logic [NM-1:0]       s_bvalid, s_bready = '0;
  logic [BIDW-1:0]     m_awid;
  logic [B_AW-1:0]     m_awaddr;
  logic [7:0]          m_awlen;
  logic [2:0]          m_awsize;
  logic [1:0]          m_awburst;
  logic                m_awvalid, m_awready = 1'b0;
  logic [B_DW-1:0]     m_wdata;
  logic [B_BEW-1:0]    m_wstrb;
  logic                m_wlast, m_wvalid, m_wready = 1'b0;
  logic [BIDW-1:0]     m_bid = '0;
  logic [1:0]          m_bresp = '0;
  logic                m_bvalid = 1'b0, m_bready, err;

  powlib_ipsaxi_wrarb #(.NM(NM), .SELW(SELW), .IDW(IDW), .B_BPD(B_BPD), .B_AW(B_AW)) dut (
    .clk(clk), .rst(rst),
    .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid),
    .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid),
    .s_bready(s_bready), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awvalid(m_awvalid),
    .m_awready(m_awready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .err(err)
  );

  int tests = 0, fails = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int              mdl_owner = -1;   // granted master, -1 when no burst is open
  bit              mdl_aw_sent = 0;  // bridge has taken the AW of the open burst
  int              mdl_rr = 0;
  logic [BIDW-1:0] mdl_awid;
  logic [B_AW-1:0] mdl_awaddr;
  logic [7:0]      mdl_awlen;
  logic [2:0]      mdl_awsize;
  logic [1:0]      mdl_awburst;
  int              beat_cnt = 0, cyc = 0, hs_cyc = 0, last_aw_lat = 0;
  bit              prev_awv = 0;
  int              grant_log[$], beat_log[$];
  int              w_hs_cnt[NM];

  always @(negedge clk) begin
    logic [NM-1:0] e_awr, e_wr, e_bv;
    logic e_awv, e_wv, e_br, e_err;
    int sel, win, k;
    cyc++;
    e_awr = '0; e_wr = '0; e_bv = '0;
    e_awv = 0; e_wv = 0; e_br = 0; e_err = 0; win = -1;
    if (!rst) begin
      sel = int'(m_bid[IDW +: SELW]);
      if (sel < NM) begin e_bv[sel] = m_bvalid; e_br = s_bready[sel]; end
      else begin e_br = 1; e_err = m_bvalid; end
      if (mdl_owner < 0) begin
        for (int i = 0; i < NM; i++) begin
          k = (mdl_rr + i) % NM;
          if (win < 0 && s_awvalid[k]) win = k;
        end
        if (win >= 0) e_awr[win] = 1'b1;
      end else if (!mdl_aw_sent) e_awv = 1;
      else begin
        e_wv = s_wvalid[mdl_owner];
        e_wr[mdl_owner] = m_wready;
      end
    end
    check("s_awready", s_awready, e_awr);
    check("s_wready", s_wready, e_wr);
    check("m_awvalid", m_awvalid, e_awv);
    check("m_wvalid", m_wvalid, e_wv);
    check("s_bvalid", s_bvalid, e_bv);
    check("m_bready", m_bready, e_br);
    check("err", err, e_err);
    if (!rst) begin
      check("s_bid", s_bid, m_bid[IDW-1:0]);
      check("s_bresp", s_bresp, m_bresp);
    end
    if (e_awv) begin
      check("m_awid", m_awid, mdl_awid);
      check("m_awaddr", m_awaddr, mdl_awaddr);
      check("m_awlen", m_awlen, mdl_awlen);
      check("m_awsize", m_awsize, mdl_awsize);
      check("m_awburst", m_awburst, mdl_awburst);
    end
    if (e_wv) begin
      check("m_wdata", m_wdata, s_wdata[mdl_owner*B_DW +: B_DW]);
      check("m_wstrb", m_wstrb, s_wstrb[mdl_owner*B_BEW +: B_BEW]);
      check("m_wlast", m_wlast, s_wlast[mdl_owner]);
    end
    for (int j = 0; j < NM; j++) if (s_wvalid[j] && s_wready[j]) w_hs_cnt[j]++;
    if (m_awvalid && !prev_awv) last_aw_lat = cyc - hs_cyc;
    prev_awv = m_awvalid;
    // advance model to the state after the coming edge
    if (rst) begin
      mdl_owner = -1; mdl_aw_sent = 0; mdl_rr = 0;
    end else if (mdl_owner < 0) begin
      if (win >= 0) begin
        mdl_owner   = win;
        mdl_awid    = {SELW'(win), s_awid[win*IDW +: IDW]};
        mdl_awaddr  = s_awaddr[win*B_AW +: B_AW];
        mdl_awlen   = s_awlen[win*8 +: 8];
        mdl_awsize  = s_awsize[win*3 +: 3];
        mdl_awburst = s_awburst[win*2 +: 2];
        grant_log.push_back(win);
        hs_cyc   = cyc;
        beat_cnt = 0;
      end
    end else if (!mdl_aw_sent) begin
      if (m_awready) mdl_aw_sent = 1;
    end else if (e_wv && m_wready) begin
      beat_cnt++;
      if (s_wlast[mdl_owner]) begin
        beat_log.push_back(beat_cnt);
        mdl_rr      = (mdl_owner + 1) % NM;
        mdl_owner   = -1;
        mdl_aw_sent = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [NM-1:0] cfg_en = '0;
  int  cfg_len = -1;
  bit  cfg_fixed = 0, b_rand = 1;
  int  p_aw = 100, p_w = 100, p_awr = 100, p_wr = 100;
  int  wleft[NM];
  logic [NM-1:0] hs_aw, hs_w;

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic drive();
    if (rst) begin
      s_awvalid = '0; s_wvalid = '0;
      for (int k = 0; k < NM; k++) wleft[k] = 0;
    end else begin
      for (int k = 0; k < NM; k++) begin
        if (hs_aw[k]) begin
          s_awvalid[k] = 1'b0;
          wleft[k] = int'(s_awlen[k*8 +: 8]) + 1;
        end else if (!s_awvalid[k] && wleft[k] == 0 && cfg_en[k] && pct(p_aw)) begin
          s_awid[k*IDW +: IDW]    = cfg_fixed ? IDW'(1) : IDW'($urandom);
          s_awaddr[k*B_AW +: B_AW] = cfg_fixed ? 32'h10 : $urandom;
          s_awlen[k*8 +: 8]       = (cfg_len < 0) ? 8'($urandom_range(0, 3)) : 8'(cfg_len);
          s_awsize[k*3 +: 3]      = 3'd2;
          s_awburst[k*2 +: 2]     = 2'd1;
          s_awvalid[k]            = 1'b1;
        end
        if (hs_w[k]) begin
          s_wvalid[k] = 1'b0;
          if (wleft[k] > 0) wleft[k]--;
        end
        if (wleft[k] > 0 && !s_wvalid[k] && pct(p_w)) begin
          s_wdata[k*B_DW +: B_DW]   = $urandom;
          s_wstrb[k*B_BEW +: B_BEW] = B_BEW'($urandom);
          s_wlast[k]                = (wleft[k] == 1);
          s_wvalid[k]               = 1'b1;
        end
      end
    end
    m_awready = pct(p_awr);
    m_wready  = pct(p_wr);
    if (b_rand) begin
      m_bvalid = 1'($urandom);
      m_bid    = BIDW'($urandom);
      m_bresp  = 2'($urandom);
      s_bready = NM'($urandom);
    end
  endtask

  task automatic step();
    @(negedge clk);
    hs_aw = s_awvalid & s_awready;
    hs_w  = s_wvalid & s_wready;
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    grant_log.delete();
    beat_log.delete();
    for (int k = 0; k < NM; k++) w_hs_cnt[k] = 0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string nm);
    int c = 0;
    while (beat_log.size() < n && c < budget) begin step(); c++; end
    check(nm, beat_log.size() >= n, 1);
  endtask

  initial begin
    for (int k = 0; k < NM; k++) wleft[k] = 0;
    hs_aw = '0; hs_w = '0;
    b_rand = 0;
    do_reset();
    peek();
    check("rst_awready", s_awready, 0);
    check("rst_awvalid", m_awvalid, 0);

    // single master 0, len=3
    cfg_en = 3'b001; cfg_len = 3; cfg_fixed = 1;
    wait_beats(1, 60, "t1_done");
    check("t1_grant", grant_log[0], 0);
    check("t1_beats", beat_log[0], 4);
    check("t1_awid", mdl_awid, 4'b0001);
    check("t1_awaddr", mdl_awaddr, 32'h10);
    check("t1_aw_lat", last_aw_lat, 1);
    cfg_fixed = 0;

    // fairness with all masters requesting continuously
    do_reset();
    cfg_en = 3'b111; cfg_len = 0;
    wait_beats(6, 120, "t2_done");
    for (int i = 0; i < 6; i++) check("t2_order", grant_log[i], i % NM);

    // m_awready held low in ADDR
    do_reset();
    cfg_en = 3'b001; cfg_len = 2; p_awr = 0;
    for (int c = 0; c < 20 && !(mdl_owner >= 0 && !mdl_aw_sent); c++) step();
    check("t3_in_addr", mdl_owner, 0);
    for (int i = 0; i < 5; i++) begin
      step(); peek();
      check("t3_awv_held", m_awvalid, 1);
      check("t3_wready_blk", s_wready, 0);
    end
    p_awr = 100;
    wait_beats(1, 40, "t3_done");
    check("t3_beats", beat_log[0], 3);

    // master 0 pushes W while master 1 owns the W channel
    do_reset();
    cfg_en = 3'b010; cfg_len = 1;
    s_wdata[B_DW-1:0] = 32'hDEADBEEF; s_wlast[0] = 1'b1; s_wvalid[0] = 1'b1;
    wait_beats(1, 40, "t4_done");
    check("t4_grant", grant_log[0], 1);
    check("t4_m0_blocked", w_hs_cnt[0], 0);
    check("t4_m1_beats", w_hs_cnt[1], 2);
    s_wvalid[0] = 1'b0;

    // reset during a DATA beat
    do_reset();
    cfg_en = 3'b001; cfg_len = 3; p_wr = 0;
    for (int c = 0; c < 30 && !(mdl_aw_sent && s_wvalid[0]); c++) step();
    check("t5_in_data", mdl_aw_sent && s_wvalid[0], 1);
    rst = 1'b1;
    step();
    rst = 1'b0; cfg_en = '0; p_wr = 100;
    peek();
    check("t5_wvalid", m_wvalid, 0);
    check("t5_awvalid", m_awvalid, 0);
    check("t5_wready", s_wready, 0);
    check("t5_idle", mdl_owner, -1);
    step(); peek();
    check("t5_wvalid2", m_wvalid, 0);

    // B routing and out-of-range index
    m_bvalid = 1'b1; m_bid = 4'b0101; m_bresp = 2'b10; s_bready = 3'b000;
    for (int i = 0; i < 2; i++) begin
      peek();
      check("t6_bvalid", s_bvalid, 3'b010);
      check("t6_bready_lo", m_bready, 0);
      check("t6_bid", s_bid, 2'b01);
      step();
    end
    s_bready = 3'b010;
    peek();
    check("t6_bready_hi", m_bready, 1);
    step();
    m_bid = 4'b1100;
    peek();
    check("t6_oor_bready", m_bready, 1);
    check("t6_oor_bvalid", s_bvalid, 0);
    check("t6_oor_err", err, 1);
    step();
    m_bvalid = 1'b0;
    peek();
    check("t6_err_clr", err, 0);
    step();

    // randomized traffic with occasional resets
    do_reset();
    cfg_en = 3'b111; cfg_len = -1; b_rand = 1;
    p_aw = 60; p_w = 70; p_awr = 60; p_wr = 70;
    for (int c = 0; c < 3000; c++) begin
      step();
      rst = ($urandom_range(0, 99) == 0);
    end
    rst = 1'b0;
    step();
    check("rand_progress", grant_log.size() > 20, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
